// File: rtl/regfile_dump_pkg.sv
// Shared register-file geometry and dump-engine state encoding for the
// debug read-out path.
package regfile_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE    = 2'd0,
    DUMP_READ    = 2'd1,
    DUMP_PRESENT = 2'd2,
    DUMP_FINISH  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks an inclusive (wrapping) register range on a spare regfile read port
// and streams {addr,data} entries out over a valid/ready handshake.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] FirstAddr,
  input  logic [ADDR_W-1:0] LastAddr,
  output logic [ADDR_W-1:0] RfReadAddr,
  input  logic [DATA_W-1:0] RfReadData,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic [DATA_W-1:0] DumpData,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   EntryCount
);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] cur, last, cur_inc;
  logic              at_last, skip_cur, accept;

  assign cur_inc  = cur + 1'b1;
  assign at_last  = (cur == last);
  assign skip_cur = SKIP_ZERO && (cur == '0);
  assign accept   = DumpValid && DumpReady;

  assign DumpValid = (state == DUMP_PRESENT);
  assign Busy      = (state != DUMP_IDLE);
  assign Done      = (state == DUMP_FINISH);

  always_comb begin
    state_nxt = state;
    unique case (state)
      DUMP_IDLE:    if (Start) state_nxt = DUMP_READ;
      DUMP_READ: begin
        if (!skip_cur)    state_nxt = DUMP_PRESENT;
        else if (at_last) state_nxt = DUMP_FINISH;
      end
      DUMP_PRESENT: if (accept) state_nxt = at_last ? DUMP_FINISH : DUMP_READ;
      DUMP_FINISH:  state_nxt = DUMP_IDLE;
      default:      state_nxt = DUMP_IDLE;
    endcase
    // Abort overrides everything except in IDLE, where it is meaningless.
    if (Abort && (state != DUMP_IDLE)) state_nxt = DUMP_IDLE;
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state      <= DUMP_IDLE;
      cur        <= '0;
      last       <= '0;
      RfReadAddr <= '0;
      DumpAddr   <= '0;
      DumpData   <= '0;
      EntryCount <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        DUMP_IDLE: begin
          if (Start) begin
            cur        <= FirstAddr;
            last       <= LastAddr;
            RfReadAddr <= FirstAddr;
            EntryCount <= '0;
          end
        end
        DUMP_READ: begin
          // $zero is stepped over without a PRESENT cycle when skipping.
          if (skip_cur) begin
            if (!at_last) begin
              cur        <= cur_inc;
              RfReadAddr <= cur_inc;
            end
          end else begin
            DumpData <= RfReadData;
            DumpAddr <= cur;
          end
        end
        DUMP_PRESENT: begin
          if (accept && !Abort) begin
            EntryCount <= EntryCount + 1'b1;
            if (!at_last) begin
              cur        <= cur_inc;
              RfReadAddr <= cur_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized self-checking bench for regfile_dump: two instances (normal and
// SKIP_ZERO) read a behavioural register array and are scored per dump.
module tb_regfile_dump;

  logic        clock = 1'b0;
  logic        Reset;
  logic        start_v [2];
  logic        abort_v [2];
  logic        ready_v [2];
  logic [4:0]  first_v [2];
  logic [4:0]  last_v  [2];
  logic [4:0]  raddr_v [2];
  logic [31:0] rdata_v [2];
  logic        valid_v [2];
  logic [4:0]  daddr_v [2];
  logic [31:0] ddata_v [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic [5:0]  cnt_v   [2];

  logic [31:0] rf [32];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign rdata_v[0] = rf[raddr_v[0]];
  assign rdata_v[1] = rf[raddr_v[1]];

  regfile_dump #(.ADDR_W(5), .DATA_W(32), .SKIP_ZERO(1'b0)) u_dump (
    .clock(clock), .Reset(Reset), .Start(start_v[0]), .Abort(abort_v[0]),
    .FirstAddr(first_v[0]), .LastAddr(last_v[0]), .RfReadAddr(raddr_v[0]),
    .RfReadData(rdata_v[0]), .DumpValid(valid_v[0]), .DumpReady(ready_v[0]),
    .DumpAddr(daddr_v[0]), .DumpData(ddata_v[0]), .Busy(busy_v[0]),
    .Done(done_v[0]), .EntryCount(cnt_v[0])
  );

  regfile_dump #(.ADDR_W(5), .DATA_W(32), .SKIP_ZERO(1'b1)) u_dump_skip (
    .clock(clock), .Reset(Reset), .Start(start_v[1]), .Abort(abort_v[1]),
    .FirstAddr(first_v[1]), .LastAddr(last_v[1]), .RfReadAddr(raddr_v[1]),
    .RfReadData(rdata_v[1]), .DumpValid(valid_v[1]), .DumpReady(ready_v[1]),
    .DumpAddr(daddr_v[1]), .DumpData(ddata_v[1]), .Busy(busy_v[1]),
    .Done(done_v[1]), .EntryCount(cnt_v[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input int d);
    chk("rst_raddr", raddr_v[d], 0);
    chk("rst_valid", valid_v[d], 0);
    chk("rst_daddr", daddr_v[d], 0);
    chk("rst_ddata", ddata_v[d], 0);
    chk("rst_busy",  busy_v[d],  0);
    chk("rst_done",  done_v[d],  0);
    chk("rst_count", cnt_v[d],   0);
  endtask

  // One full dump on instance d; expectations come from a plain walk of the
  // range over the current register array contents.
  task automatic run_dump(input int d, input int first, input int last,
                          input int stall_idx, input int stall_len, input int abort_idx,
                          input bit rand_ready, input bit busy_start);
    int          exp_a[$];
    logic [31:0] exp_d[$];
    int          a, idx, cyc, stalled, last_acc;
    bit          fin;
    logic [4:0]  hold_a;
    logic [31:0] hold_d;
    a = first;
    while (1) begin
      if (!(d == 1 && a == 0)) begin
        exp_a.push_back(a);
        exp_d.push_back(rf[a]);
      end
      if (a == last) break;
      a = (a + 1) % 32;
    end

    start_v[d] = 1'b1;
    first_v[d] = 5'(first);
    last_v[d]  = 5'(last);
    ready_v[d] = 1'b0;
    step();
    start_v[d] = 1'b0;
    chk("busy_after_start", busy_v[d], 1);

    idx = 0; cyc = 0; stalled = 0; last_acc = -1; fin = 0;
    hold_a = '0; hold_d = '0;
    while (!fin && cyc < 300) begin
      if (done_v[d]) begin
        chk("done_entries", idx, exp_a.size());
        chk("done_count", cnt_v[d], exp_a.size());
        step();
        chk("done_one_cycle", done_v[d], 0);
        chk("idle_after_done", busy_v[d], 0);
        fin = 1;
      end else begin
        if (valid_v[d]) begin
          if (idx == abort_idx) begin
            abort_v[d] = 1'b1;
            ready_v[d] = 1'b0;
            step();
            abort_v[d] = 1'b0;
            chk("abort_valid", valid_v[d], 0);
            chk("abort_busy", busy_v[d], 0);
            chk("abort_count", cnt_v[d], idx);
            step();
            chk("abort_no_done", done_v[d], 0);
            return;
          end
          if (idx >= exp_a.size()) begin
            chk("extra_entry", idx, exp_a.size());
            ready_v[d] = 1'b0;
            return;
          end
          if (idx == stall_idx && stalled < stall_len) begin
            if (stalled == 0) begin
              hold_a = daddr_v[d];
              hold_d = ddata_v[d];
              if (busy_start) begin
                start_v[d] = 1'b1;
                first_v[d] = 5'((first + 13) % 32);
                last_v[d]  = 5'((first + 14) % 32);
              end
            end else begin
              chk("stall_valid", valid_v[d], 1);
              chk("stall_addr", daddr_v[d], hold_a);
              chk("stall_data", ddata_v[d], hold_d);
            end
            stalled++;
            ready_v[d] = 1'b0;
          end else begin
            ready_v[d] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (ready_v[d]) begin
            chk("entry_addr", daddr_v[d], exp_a[idx]);
            chk("entry_data", ddata_v[d], exp_d[idx]);
            if (d == 0 && !rand_ready && stall_len == 0 && last_acc >= 0)
              chk("throughput", cyc - last_acc, 2);
            last_acc = cyc;
            idx++;
          end
        end else begin
          ready_v[d] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        step();
        start_v[d] = 1'b0;
        cyc++;
      end
    end
    if (!fin) chk("dump_timeout", 0, 1);
    ready_v[d] = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; abort_v[d] = 1'b0; ready_v[d] = 1'b0;
      first_v[d] = '0;   last_v[d]  = '0;
    end
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    step();
    step();
    check_reset_outputs(0);
    check_reset_outputs(1);
    Reset = 1'b0;
    step();

    // Full range, ready held high
    run_dump(0, 0, 31, -1, 0, -1, 1'b0, 1'b0);
    // Wrapping range
    run_dump(0, 30, 2, -1, 0, -1, 1'b0, 1'b0);
    // Back-pressure on entry 5 with a Start attempt while busy
    run_dump(0, 0, 10, 5, 7, -1, 1'b0, 1'b1);
    // Abort on the third entry, then a clean dump
    run_dump(0, 8, 20, -1, 0, 2, 1'b0, 1'b0);
    run_dump(0, 8, 12, -1, 0, -1, 1'b0, 1'b0);

    // Abort in IDLE is ignored
    abort_v[0] = 1'b1;
    step();
    abort_v[0] = 1'b0;
    chk("idle_abort_busy", busy_v[0], 0);
    chk("idle_abort_count", cnt_v[0], 5);

    // Skipping $zero
    run_dump(1, 0, 3, -1, 0, -1, 1'b0, 1'b0);
    run_dump(1, 0, 0, -1, 0, -1, 1'b0, 1'b0);
    run_dump(1, 29, 1, -1, 0, -1, 1'b0, 1'b0);

    // Reset mid-dump with Start and Abort also asserted
    start_v[0] = 1'b1; first_v[0] = 5'd4; last_v[0] = 5'd20; ready_v[0] = 1'b0;
    step();
    start_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    Reset = 1'b1; start_v[0] = 1'b1; abort_v[0] = 1'b1;
    step();
    check_reset_outputs(0);
    Reset = 1'b0; start_v[0] = 1'b0; abort_v[0] = 1'b0;
    step();
    chk("post_reset_idle", busy_v[0], 0);

    // Randomized dumps over random register contents
    for (int t = 0; t < 12; t++) begin
      int d;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      d = int'($urandom_range(0, 1));
      run_dump(d, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               -1, 0, -1, 1'b1, 1'b0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
